// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_unit_pkg;

    localparam int unsigned FetchBeats = 4;
    localparam logic        ChipEnable = 1'b1;
    localparam logic [1:0]  LastBeat   = 2'(FetchBeats - 1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StReq   = 3'd1,
        StWait  = 3'd2,
        StHold  = 3'd3,
        StDrain = 3'd4
    } fetch_state_e;

    // Advance the beat index, saturating at the last beat.
    function automatic logic [1:0] next_beat(input logic [1:0] beat);
        return (beat == LastBeat) ? beat : beat + 2'd1;
    endfunction

endpackage

// File: rtl/if_fetch_unit_perf_cnt.sv
// Fetch performance counters: completed handoffs and ID back-pressure cycles.
module if_fetch_unit_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        handoff_i,
    input  logic        stall_i,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] stall_cnt_o
);

    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Free-running increments, wrapping mod 2^32.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, handoff_i};
        stall_cnt_d = stall_cnt_q + {31'd0, stall_i};
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: one 32-bit word as four little-endian byte reads, handed to ID via
// valid/ready. Define FETCH_PERF_EN to add handoff/stall performance counters.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 32,
    parameter int unsigned BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ce_i,
    input  logic              flush_i,
    output logic              pc_stall_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ready_i,
    input  logic              mem_rvalid_i,
    input  logic [BYTE_W-1:0] mem_rdata_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    input  logic              id_ready_i
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt_o,
    output logic [31:0]       perf_stall_cnt_o
`endif
);

    fetch_state_e      state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;

    // Next-state logic, byte assembly and PC stall.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        pc_stall_o = 1'b1;
        unique case (state_q)
            StIdle: begin
                // flush_i has no effect here; the PC advances on the capture edge.
                pc_stall_o = 1'b0;
                if (ce_i == ChipEnable) begin
                    pc_d    = pc_i;
                    beat_d  = 2'd0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (flush_i) begin
                    state_d = StIdle;
                end else if (mem_ready_i) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (flush_i) begin
                    // Data arriving in the flush cycle itself leaves nothing to drain.
                    state_d = mem_rvalid_i ? StIdle : StDrain;
                end else if (mem_rvalid_i) begin
                    inst_d[BYTE_W*int'(beat_q) +: BYTE_W] = mem_rdata_i;
                    if (beat_q == LastBeat) begin
                        state_d = StHold;
                    end else begin
                        beat_d  = next_beat(beat_q);
                        state_d = StReq;
                    end
                end
            end
            StHold: begin
                if (flush_i) begin
                    state_d = StIdle;
                end else if (id_ready_i) begin
                    pc_stall_o = 1'b0;
                    if (ce_i == ChipEnable) begin
                        pc_d    = pc_i;
                        beat_d  = 2'd0;
                        state_d = StReq;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StDrain: begin
                if (mem_rvalid_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            beat_q  <= 2'd0;
            pc_q    <= '0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    assign mem_req_o    = (state_q == StReq);
    assign mem_addr_o   = {pc_q[ADDR_W-1:2], beat_q};
    assign inst_o       = inst_q;
    assign inst_pc_o    = pc_q;
    assign inst_valid_o = (state_q == StHold);

`ifdef FETCH_PERF_EN
    logic handoff;
    logic id_stall;

    // A flushed HOLD is neither a handoff nor a stall.
    assign handoff  = inst_valid_o & id_ready_i & ~flush_i;
    assign id_stall = inst_valid_o & ~id_ready_i & ~flush_i;

    if_fetch_unit_perf_cnt u_perf_cnt (
        .clk         (clk),
        .rst         (rst),
        .handoff_i   (handoff),
        .stall_i     (id_stall),
        .fetch_cnt_o (perf_fetch_cnt_o),
        .stall_cnt_o (perf_stall_cnt_o)
    );
`endif

endmodule
